div_even_monitor: RTL and testbench

//   Receive-side checker for the even clock divider: samples a divided clock in the

---
 rtl/div_even_monitor_if.sv | 22 ++
 rtl/div_even_monitor.sv | 150 +++++++++++++++
 tb/tb_div_even_monitor.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/div_even_monitor_if.sv
// Bundle between an even-divider output and its receive-side monitor.
// The monitor takes the slave modport; the divider side / bench takes master.
interface div_even_monitor_if #(
    parameter int CW = 8
) ();
    logic          div_in;
    logic [CW-1:0] period_o;
    logic [CW-1:0] high_o;
    logic          meas_vld;
    logic          locked;
    logic          err;

    modport master (
        output div_in,
        input  period_o, high_o, meas_vld, locked, err
    );

    modport slave (
        input  div_in,
        output period_o, high_o, meas_vld, locked, err
    );
endinterface

// File: rtl/div_even_monitor.sv
// Receive-side checker for an even clock divider: measures period/high time of div_in
// in clkin cycles, locks after LOCK_CNT good periods. Option: DIV_MON_STICKY_ERR_EN.
module div_even_monitor #(
    parameter int NUM      = 6,
    parameter int FEN      = NUM / 2,
    parameter int CW       = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic              clkin,
    input  logic              rst_n,
    div_even_monitor_if.slave mon
);
    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] NUM_C   = CW'(NUM);
    localparam logic [CW-1:0] FEN_C   = CW'(FEN);
    localparam logic [CW-1:0] STALL_C = CW'(2 * NUM);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED
    } state_e;

    state_e        state_q, state_d;
    logic          div_q;
    logic [CW-1:0] per_cnt_q, per_cnt_d;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] high_q, high_d;
    logic          vld_q, vld_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;

    logic rise;
    logic match;
    logic stall;
    logic err_evt;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= 1'b0;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            good_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            vld_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= mon.div_in;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            good_q    <= good_d;
            period_q  <= period_d;
            high_q    <= high_d;
            vld_q     <= vld_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        rise  = mon.div_in & ~div_q;
        // Measurement uses the pre-update counts, i.e. the period that just ended.
        match = (per_cnt_q == NUM_C) && (hi_cnt_q == FEN_C);
        // A rise on the stall-threshold cycle is a normal (if mismatched) period.
        stall = !rise && (per_cnt_q == STALL_C) && (state_q != IDLE);

        if (rise)                     per_cnt_d = CW'(1);
        else if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + CW'(1);
        else                          per_cnt_d = per_cnt_q;

        if (rise)                                    hi_cnt_d = CW'(1);
        else if (mon.div_in && (hi_cnt_q != CNT_MAX)) hi_cnt_d = hi_cnt_q + CW'(1);
        else                                         hi_cnt_d = hi_cnt_q;

        state_d  = state_q;
        good_d   = good_q;
        period_d = period_q;
        high_d   = high_q;
        vld_d    = 1'b0;
        err_evt  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) state_d = ACQ;
            end
            ACQ: begin
                if (rise) begin
                    period_d = per_cnt_q;
                    high_d   = hi_cnt_q;
                    vld_d    = 1'b1;
                    if (match) begin
                        good_d = good_q + GW'(1);
                        if (good_q + GW'(1) == LOCK_C) state_d = LOCKED;
                    end else begin
                        good_d  = '0;
                        err_evt = 1'b1;
                    end
                end else if (stall) begin
                    good_d  = '0;
                    err_evt = 1'b1;
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_d = per_cnt_q;
                    high_d   = hi_cnt_q;
                    vld_d    = 1'b1;
                    if (!match) begin
                        good_d  = '0;
                        err_evt = 1'b1;
                        state_d = ACQ;
                    end
                end else if (stall) begin
                    good_d  = '0;
                    err_evt = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                good_d  = '0;
                state_d = IDLE;
            end
        endcase

        locked_d = (state_d == LOCKED);

`ifdef DIV_MON_STICKY_ERR_EN
        err_d = err_q | err_evt;
`else
        err_d = err_evt;
`endif
    end

    assign mon.period_o = period_q;
    assign mon.high_o   = high_q;
    assign mon.meas_vld = vld_q;
    assign mon.locked   = locked_q;
    assign mon.err      = err_q;

endmodule

// File: tb/tb_div_even_monitor.sv
// Directed bench for div_even_monitor (NUM=6, FEN=3, LOCK_CNT=4); each period call
// checks the measurement reported on its opening rise and that the rest stays quiet.
module tb_div_even_monitor;
    localparam int CW = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    logic sticky_set;
    int   last_per;
    int   last_hi;

    div_even_monitor_if #(.CW(CW)) bus ();

    div_even_monitor #(
        .NUM      (6),
        .FEN      (3),
        .CW       (CW),
        .LOCK_CNT (4)
    ) dut (
        .clkin (clk),
        .rst_n (rst_n),
        .mon   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One div_in period of hi high / lo low cycles. vld/p/h/e/lk describe the
    // outputs right after its opening rise (the measurement of the previous period).
    task automatic per(input string tag, input int hi, input int lo,
                       input int vld, input int p, input int h, input int e, input int lk);
        int          extra_vld;
        int          extra_err;
        logic [31:0] eexp;
        logic        quiet_err;
        extra_vld = 0;
        extra_err = 0;
        bus.div_in = 1'b1;
        tick();
        if (vld != 0) begin
            last_per = p;
            last_hi  = h;
        end
        if (e != 0) sticky_set = 1'b1;
`ifdef DIV_MON_STICKY_ERR_EN
        eexp      = 32'(sticky_set);
        quiet_err = sticky_set;
`else
        eexp      = e;
        quiet_err = 1'b0;
`endif
        chk({tag, "/vld"},    32'(bus.meas_vld), vld);
        chk({tag, "/period"}, 32'(bus.period_o), last_per);
        chk({tag, "/high"},   32'(bus.high_o),   last_hi);
        chk({tag, "/err"},    32'(bus.err),      eexp);
        chk({tag, "/locked"}, 32'(bus.locked),   lk);
        for (int i = 1; i < hi + lo; i++) begin
            bus.div_in = (i < hi);
            tick();
            if (bus.meas_vld) extra_vld++;
            if (bus.err !== quiet_err) extra_err++;
        end
        chk({tag, "/quiet_vld"}, extra_vld, 0);
        chk({tag, "/quiet_err"}, extra_err, 0);
    endtask

    initial begin
        int first_unlock;
        int first_err;
        int nerr;
        int nvld;
        n_vec      = 0;
        n_bad      = 0;
        sticky_set = 1'b0;
        last_per   = 0;
        last_hi    = 0;
        rst_n      = 1'b0;
        bus.div_in = 1'b0;
        tick();
        tick();
        chk("rst/period", 32'(bus.period_o), 0);
        chk("rst/high",   32'(bus.high_o),   0);
        chk("rst/vld",    32'(bus.meas_vld), 0);
        chk("rst/locked", 32'(bus.locked),   0);
        chk("rst/err",    32'(bus.err),      0);
        rst_n = 1'b1;
        tick();

        // Continuous 3h/3l: first rise only arms, lock on the 5th rise.
        per("t1_p1", 3, 3, 0, 0, 0, 0, 0);
        per("t1_p2", 3, 3, 1, 6, 3, 0, 0);
        per("t1_p3", 3, 3, 1, 6, 3, 0, 0);
        per("t1_p4", 3, 3, 1, 6, 3, 0, 0);
        per("t1_p5", 3, 3, 1, 6, 3, 0, 1);
        per("t1_p6", 3, 3, 1, 6, 3, 0, 1);

        // One 4h/2l period while locked, then relock after 4 good periods.
        per("t2_bad",  4, 2, 1, 6, 3, 0, 1);
        per("t2_det",  3, 3, 1, 6, 4, 1, 0);
        per("t2_g1",   3, 3, 1, 6, 3, 0, 0);
        per("t2_g2",   3, 3, 1, 6, 3, 0, 0);
        per("t2_g3",   3, 3, 1, 6, 3, 0, 0);
        per("t2_g4",   3, 3, 1, 6, 3, 0, 1);

        // 3h/4l continuous: every measurement is period 7 and flags err.
        per("t3_p1", 3, 4, 1, 6, 3, 0, 1);
        per("t3_p2", 3, 4, 1, 7, 3, 1, 0);
        per("t3_p3", 3, 4, 1, 7, 3, 1, 0);
        per("t3_p4", 3, 4, 1, 7, 3, 1, 0);

        // Rise exactly at per_cnt==12: measured normally, state stays ACQ.
        per("rw_66",   6, 6, 1, 7, 3, 1, 0);
        per("rw_meas", 3, 3, 1, 12, 6, 1, 0);
        per("rw_g1",   3, 3, 1, 6, 3, 0, 0);
        per("rw_g2",   3, 3, 1, 6, 3, 0, 0);
        per("rw_g3",   3, 3, 1, 6, 3, 0, 0);
        per("rw_g4",   3, 3, 1, 6, 3, 0, 1);

        // Stall while locked: one event when per_cnt hits 12, none afterwards.
        first_unlock = 0;
        first_err    = 0;
        nerr         = 0;
        nvld         = 0;
        for (int i = 1; i <= 20; i++) begin
            bus.div_in = 1'b0;
            tick();
            if (!bus.locked && first_unlock == 0) first_unlock = i;
            if (bus.err) begin
                nerr++;
                if (first_err == 0) first_err = i;
            end
            if (bus.meas_vld) nvld++;
        end
        chk("stall/unlock_at", first_unlock, 7);
        chk("stall/vld",       nvld,         0);
`ifdef DIV_MON_STICKY_ERR_EN
        chk("stall/err_held",  nerr,         20);
`else
        chk("stall/err_cnt",   nerr,         1);
        chk("stall/err_at",    first_err,    7);
`endif
        per("t4_p1", 3, 3, 0, 0, 0, 0, 0);
        per("t4_p2", 3, 3, 1, 6, 3, 0, 0);
        per("t4_p3", 3, 3, 1, 6, 3, 0, 0);
        per("t4_p4", 3, 3, 1, 6, 3, 0, 0);
        per("t4_p5", 3, 3, 1, 6, 3, 0, 1);

        // Asynchronous reset while locked clears everything without a clock edge.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5/period", 32'(bus.period_o), 0);
        chk("t5/high",   32'(bus.high_o),   0);
        chk("t5/vld",    32'(bus.meas_vld), 0);
        chk("t5/locked", 32'(bus.locked),   0);
        chk("t5/err",    32'(bus.err),      0);
        sticky_set = 1'b0;
        last_per   = 0;
        last_hi    = 0;
        tick();
        tick();
        rst_n = 1'b1;
        per("t5_p1", 3, 3, 0, 0, 0, 0, 0);
        per("t5_p2", 3, 3, 1, 6, 3, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
